noc_bridge_vc_tx: RTL and testbench

Transmit half of the credit-based (virtual-channel) NoC bridge. Accepts request and response flits from the local FlooNoC router, arbitrates between them subject to per-channel remote credits, and emits one `axis_packet_t` per cycle towards the serial-link AXI-Stream input. Each packet can also carry credits for flits the local receive side has consumed. The block sits directly upstream of the AXIS interface and downstream of the router's output ports.

---
 rtl/noc_bridge_pkg.sv | 41 ++++
 rtl/noc_bridge_credit_cnt.sv | 21 ++
 rtl/noc_bridge_vc_tx.sv | 146 ++++++++++++++
 tb/tb_noc_bridge_vc_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_bridge_pkg.sv
// rtl/noc_bridge_pkg.sv - shared types and constants for the credit-based NoC bridge
package noc_bridge_pkg;

    localparam int NumCred_NocBridge = 8;
    localparam int BridgeCredWidth   = $clog2(NumCred_NocBridge + 1);

    localparam int FlitReqWidth  = 32;
    localparam int FlitRspWidth  = 24;
    localparam int FlitDataWidth = 32;

    typedef logic [FlitReqWidth-1:0]    flit_req_data_t;
    typedef logic [FlitRspWidth-1:0]    flit_rsp_data_t;
    typedef logic [FlitDataWidth-1:0]   flit_data_t;
    typedef logic [BridgeCredWidth-1:0] bridge_credit_t;

    typedef enum logic {
        request  = 1'b0,
        response = 1'b1
    } channel_hdr_e;

    typedef struct packed {
        channel_hdr_e data_hdr;
        flit_data_t   data;
    } data_bits_t;

    typedef struct packed {
        logic           data_validity;
        channel_hdr_e   credits_hdr;
        bridge_credit_t credits;
    } user_bits_t;

    typedef struct packed {
        data_bits_t tdata;
        user_bits_t tuser;
    } axis_packet_t;

    function automatic channel_hdr_e other_channel(input channel_hdr_e c);
        return (c == request) ? response : request;
    endfunction

endpackage

// File: rtl/noc_bridge_credit_cnt.sv
// rtl/noc_bridge_credit_cnt.sv - credit counter applying the net of increment and decrement per cycle
module noc_bridge_credit_cnt #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] rst_val,
    input  logic [Width-1:0] inc,
    input  logic [Width-1:0] dec,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= rst_val;
        end else begin
            count <= count + inc - dec;
        end
    end

endmodule

// File: rtl/noc_bridge_vc_tx.sv
// rtl/noc_bridge_vc_tx.sv - transmit side of the VC bridge: credit-gated arbitration, credit piggyback, AXIS register
module noc_bridge_vc_tx
    import noc_bridge_pkg::*;
#(
    parameter int NumCred = NumCred_NocBridge
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  flit_req_data_t req_data_i,
    input  logic           rsp_valid_i,
    output logic           rsp_ready_o,
    input  flit_rsp_data_t rsp_data_i,
    input  logic           req_consumed_i,
    input  logic           rsp_consumed_i,
    input  logic           cred_valid_i,
    input  channel_hdr_e   cred_hdr_i,
    input  bridge_credit_t cred_i,
    output logic           axis_tvalid_o,
    input  logic           axis_tready_i,
    output data_bits_t     axis_tdata_o,
    output user_bits_t     axis_tuser_o
);

    localparam int CW = $clog2(NumCred + 1);
    localparam logic [CW-1:0] CredMax = CW'(NumCred);

    logic [CW-1:0] tx_cred_req, tx_cred_rsp, rx_owed_req, rx_owed_rsp;
    logic [CW-1:0] tx_inc_req, tx_inc_rsp, owed_dec_req, owed_dec_rsp;
    logic [CW-1:0] cred_amt;
    channel_hdr_e  data_ptr, cred_ptr, data_sel, cred_sel;
    logic          req_elig, rsp_elig, req_nz, rsp_nz;
    logic          data_any, cred_any, load_en, load;
    axis_packet_t  pkt_d, pkt_q;

    assign req_elig = req_valid_i && (tx_cred_req != '0);
    assign rsp_elig = rsp_valid_i && (tx_cred_rsp != '0);
    assign req_nz   = (rx_owed_req != '0);
    assign rsp_nz   = (rx_owed_rsp != '0);
    assign data_any = req_elig || rsp_elig;
    assign cred_any = req_nz || rsp_nz;

    // Gating on rst_i keeps the ready outputs low while counters sit at their reset values.
    assign load_en = !axis_tvalid_o || axis_tready_i;
    assign load    = load_en && (data_any || cred_any) && !rst_i;

    assign req_ready_o = load && req_elig && (data_sel == request);
    assign rsp_ready_o = load && rsp_elig && (data_sel == response);

    always_comb begin
        data_sel = request;
        if (req_elig && rsp_elig) begin
            data_sel = data_ptr;
        end else if (rsp_elig) begin
            data_sel = response;
        end

        cred_sel = request;
        if (req_nz && rsp_nz) begin
            cred_sel = cred_ptr;
        end else if (rsp_nz) begin
            cred_sel = response;
        end
        cred_amt = (cred_sel == request) ? rx_owed_req : rx_owed_rsp;

        pkt_d                   = '0;
        pkt_d.tdata.data_hdr    = response;
        pkt_d.tuser.credits_hdr = response;
        if (data_any) begin
            pkt_d.tdata.data_hdr       = data_sel;
            pkt_d.tdata.data           = (data_sel == request) ? flit_data_t'(req_data_i)
                                                                : flit_data_t'(rsp_data_i);
            pkt_d.tuser.data_validity  = 1'b1;
        end
        if (cred_any) begin
            pkt_d.tuser.credits_hdr = cred_sel;
            pkt_d.tuser.credits     = bridge_credit_t'(cred_amt);
        end
    end

    // The whole owed count is returned at once, so the decrement equals the current count.
    assign tx_inc_req   = (cred_valid_i && cred_hdr_i == request)  ? CW'(cred_i) : '0;
    assign tx_inc_rsp   = (cred_valid_i && cred_hdr_i == response) ? CW'(cred_i) : '0;
    assign owed_dec_req = (load && cred_any && cred_sel == request)  ? rx_owed_req : '0;
    assign owed_dec_rsp = (load && cred_any && cred_sel == response) ? rx_owed_rsp : '0;

    noc_bridge_credit_cnt #(.Width(CW)) u_tx_cred_req (
        .clk(clk_i), .rst(rst_i), .rst_val(CredMax),
        .inc(tx_inc_req), .dec(CW'(req_ready_o)), .count(tx_cred_req)
    );

    noc_bridge_credit_cnt #(.Width(CW)) u_tx_cred_rsp (
        .clk(clk_i), .rst(rst_i), .rst_val(CredMax),
        .inc(tx_inc_rsp), .dec(CW'(rsp_ready_o)), .count(tx_cred_rsp)
    );

    noc_bridge_credit_cnt #(.Width(CW)) u_rx_owed_req (
        .clk(clk_i), .rst(rst_i), .rst_val('0),
        .inc(CW'(req_consumed_i)), .dec(owed_dec_req), .count(rx_owed_req)
    );

    noc_bridge_credit_cnt #(.Width(CW)) u_rx_owed_rsp (
        .clk(clk_i), .rst(rst_i), .rst_val('0),
        .inc(CW'(rsp_consumed_i)), .dec(owed_dec_rsp), .count(rx_owed_rsp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_ptr <= request;
            cred_ptr <= request;
        end else begin
            if (load && data_any) begin
                data_ptr <= other_channel(data_sel);
            end
            if (load && cred_any) begin
                cred_ptr <= other_channel(cred_sel);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            axis_tvalid_o <= 1'b0;
            pkt_q         <= '0;
        end else if (load) begin
            axis_tvalid_o <= 1'b1;
            pkt_q         <= pkt_d;
        end else if (axis_tready_i) begin
            axis_tvalid_o <= 1'b0;
        end
    end

    assign axis_tdata_o = pkt_q.tdata;
    assign axis_tuser_o = pkt_q.tuser;

`ifndef SYNTHESIS
    a_tx_cred_req_max: assert property (@(posedge clk_i) disable iff (rst_i) tx_cred_req <= CredMax);
    a_tx_cred_rsp_max: assert property (@(posedge clk_i) disable iff (rst_i) tx_cred_rsp <= CredMax);
    a_rx_owed_req_max: assert property (@(posedge clk_i) disable iff (rst_i) rx_owed_req <= CredMax);
    a_rx_owed_rsp_max: assert property (@(posedge clk_i) disable iff (rst_i) rx_owed_rsp <= CredMax);
    a_axis_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        axis_tvalid_o && !axis_tready_i |=> axis_tvalid_o && $stable(axis_tdata_o) && $stable(axis_tuser_o));
`endif

endmodule

// File: tb/tb_noc_bridge_vc_tx.sv
// tb/tb_noc_bridge_vc_tx.sv - directed vector and sequence bench for noc_bridge_vc_tx
module tb_noc_bridge_vc_tx;
    import noc_bridge_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0, rsp_valid = 1'b0;
    logic           req_ready, rsp_ready;
    flit_req_data_t req_data = '0;
    flit_rsp_data_t rsp_data = '0;
    logic           req_cons = 1'b0, rsp_cons = 1'b0;
    logic           cred_valid = 1'b0;
    channel_hdr_e   cred_hdr = request;
    bridge_credit_t cred = '0;
    logic           tvalid;
    logic           tready = 1'b1;
    data_bits_t     tdata;
    user_bits_t     tuser;

    int errors = 0;
    int checks = 0;

    noc_bridge_vc_tx #(.NumCred(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_data_i(rsp_data),
        .req_consumed_i(req_cons), .rsp_consumed_i(rsp_cons),
        .cred_valid_i(cred_valid), .cred_hdr_i(cred_hdr), .cred_i(cred),
        .axis_tvalid_o(tvalid), .axis_tready_i(tready),
        .axis_tdata_o(tdata), .axis_tuser_o(tuser)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         req_v, rsp_v;
        logic [31:0]  req_d;
        logic [23:0]  rsp_d;
        logic         req_c, rsp_c;
        logic         e_req_rdy, e_rsp_rdy, e_tvalid;
        channel_hdr_e e_hdr;
        logic         e_dv;
        logic [31:0]  e_data;
        channel_hdr_e e_chdr;
        logic [3:0]   e_cred;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic rv, logic sv, logic [31:0] rd, logic [23:0] sd, logic rc, logic sc,
                                logic err, logic esr, logic etv, channel_hdr_e eh, logic edv,
                                logic [31:0] ed, channel_hdr_e ech, logic [3:0] ec);
        vec_t v;
        v.req_v = rv; v.rsp_v = sv; v.req_d = rd; v.rsp_d = sd; v.req_c = rc; v.rsp_c = sc;
        v.e_req_rdy = err; v.e_rsp_rdy = esr; v.e_tvalid = etv; v.e_hdr = eh; v.e_dv = edv;
        v.e_data = ed; v.e_chdr = ech; v.e_cred = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; rsp_valid = 1'b0; req_cons = 1'b0; rsp_cons = 1'b0;
        cred_valid = 1'b0; tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] pk_data(channel_hdr_e h, logic [31:0] d);
        data_bits_t x;
        x.data_hdr = h;
        x.data     = d;
        return 64'(x);
    endfunction

    function automatic logic [63:0] pk_user(logic dv, channel_hdr_e h, logic [3:0] c);
        user_bits_t x;
        x.data_validity = dv;
        x.credits_hdr   = h;
        x.credits       = c;
        return 64'(x);
    endfunction

    initial begin
        int cnt;
        vecs[0]  = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 0, response, 0, 32'h0,        response, 4'd0);
        vecs[1]  = mk(1, 0, 32'hDEADBEEF, 24'h0,      0, 0, 1, 0, 1, request,  1, 32'hDEADBEEF, response, 4'd0);
        vecs[2]  = mk(1, 1, 32'h000000A2, 24'hC0FFEE, 0, 0, 0, 1, 1, response, 1, 32'h00C0FFEE, response, 4'd0);
        vecs[3]  = mk(1, 1, 32'h000000A3, 24'h0000B3, 0, 0, 1, 0, 1, request,  1, 32'h000000A3, response, 4'd0);
        vecs[4]  = mk(1, 1, 32'h000000A4, 24'hFFFFFF, 1, 0, 0, 1, 1, response, 1, 32'h00FFFFFF, response, 4'd0);
        vecs[5]  = mk(0, 0, 32'h0,        24'h0,      0, 1, 0, 0, 1, response, 0, 32'h0,        request,  4'd1);
        vecs[6]  = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 1, response, 0, 32'h0,        response, 4'd1);
        vecs[7]  = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 0, response, 0, 32'h0,        response, 4'd0);
        vecs[8]  = mk(0, 0, 32'h0,        24'h0,      1, 1, 0, 0, 0, response, 0, 32'h0,        response, 4'd0);
        vecs[9]  = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 1, response, 0, 32'h0,        request,  4'd1);
        vecs[10] = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 1, response, 0, 32'h0,        response, 4'd1);
        vecs[11] = mk(0, 0, 32'h0,        24'h0,      0, 0, 0, 0, 0, response, 0, 32'h0,        response, 4'd0);

        // Reset state, with a request waiting to confirm nothing is accepted during reset.
        req_valid = 1'b1;
        step();
        chk("reset_tvalid", 64'(tvalid), 64'd0);
        chk("reset_tdata", 64'(tdata), 64'd0);
        chk("reset_tuser", 64'(tuser), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].req_v; rsp_valid = vecs[i].rsp_v;
            req_data  = vecs[i].req_d; rsp_data  = vecs[i].rsp_d;
            req_cons  = vecs[i].req_c; rsp_cons  = vecs[i].rsp_c;
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_req_rdy));
            chk($sformatf("v%0d_rsp_ready", i), 64'(rsp_ready), 64'(vecs[i].e_rsp_rdy));
            step();
            chk($sformatf("v%0d_tvalid", i), 64'(tvalid), 64'(vecs[i].e_tvalid));
            if (vecs[i].e_tvalid) begin
                chk($sformatf("v%0d_tdata", i), 64'(tdata), pk_data(vecs[i].e_hdr, vecs[i].e_data));
                chk($sformatf("v%0d_tuser", i), 64'(tuser),
                    pk_user(vecs[i].e_dv, vecs[i].e_chdr, vecs[i].e_cred));
            end
        end
        req_valid = 1'b0; rsp_valid = 1'b0; req_cons = 1'b0; rsp_cons = 1'b0;

        // Credit exhaustion, no head-of-line blocking, and refill.
        do_reset();
        req_valid = 1'b1; req_data = 32'h11110000;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready) cnt++;
            step();
        end
        chk("exhaust_count", 64'(cnt), 64'd8);
        #1;
        chk("exhaust_req_ready", 64'(req_ready), 64'd0);
        rsp_valid = 1'b1;
        #1;
        chk("nohol_rsp_ready", 64'(rsp_ready), 64'd1);
        step();
        rsp_valid = 1'b0;
        cred_valid = 1'b1; cred_hdr = request; cred = 4'd3;
        #1;
        chk("refill_same_cycle_ready", 64'(req_ready), 64'd0);
        step();
        cred_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (req_ready) cnt++;
            step();
        end
        chk("refill_count", 64'(cnt), 64'd3);
        req_valid = 1'b0;

        // Backpressure hold with consumed pulses, then a credit-only packet.
        do_reset();
        tready = 1'b0;
        req_valid = 1'b1; req_data = 32'h12345678;
        #1;
        chk("bp_load_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_cons = (i < 5);
            step();
            chk($sformatf("bp_hold_%0d", i), {tvalid, 64'(tdata), 64'(tuser)},
                {1'b1, pk_data(request, 32'h12345678), pk_user(1'b1, response, 4'd0)});
        end
        req_cons = 1'b0;
        chk("bp_owed_req", 64'(dut.u_rx_owed_req.count), 64'd5);
        tready = 1'b1;
        step();
        chk("pb_tvalid", 64'(tvalid), 64'd1);
        chk("pb_tdata", 64'(tdata), pk_data(response, 32'h0));
        chk("pb_tuser", 64'(tuser), pk_user(1'b0, request, 4'd5));
        step();
        chk("pb_tvalid_drop", 64'(tvalid), 64'd0);

        // Data load and credit return on the same channel in one cycle.
        do_reset();
        req_valid = 1'b1;
        repeat (4) step();
        chk("simul_pre", 64'(dut.u_tx_cred_req.count), 64'd4);
        cred_valid = 1'b1; cred_hdr = request; cred = 4'd2;
        #1;
        chk("simul_ready", 64'(req_ready), 64'd1);
        step();
        cred_valid = 1'b0; req_valid = 1'b0;
        chk("simul_tx_cred", 64'(dut.u_tx_cred_req.count), 64'd5);

        // Asynchronous reset while a packet is held.
        do_reset();
        tready = 1'b0;
        req_valid = 1'b1; req_data = 32'hCAFEF00D;
        step();
        req_valid = 1'b0; req_cons = 1'b1;
        step();
        req_cons = 1'b0;
        chk("midrst_pre_tvalid", 64'(tvalid), 64'd1);
        #2;
        rst = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(tvalid), 64'd0);
        chk("midrst_tdata", 64'(tdata), 64'd0);
        chk("midrst_tuser", 64'(tuser), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_tx_req", 64'(dut.u_tx_cred_req.count), 64'd8);
        chk("midrst_tx_rsp", 64'(dut.u_tx_cred_rsp.count), 64'd8);
        chk("midrst_owed_req", 64'(dut.u_rx_owed_req.count), 64'd0);
        chk("midrst_owed_rsp", 64'(dut.u_rx_owed_rsp.count), 64'd0);
        tready = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
